// File: rtl/execute_pkg.sv
// Shared CPU definitions for the execute stage.
//   XLEN       : default datapath width
//   alu_op_e   : 4-bit ALU operation codes
//   fwd_sel_e  : 2-bit operand forwarding selects from the hazard unit
//   SHAMT_W    : width of the shift-amount field taken from operand B
package execute_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,  // value read from the register file
    FWD_WB      = 2'b01,  // writeback-stage result
    FWD_MEM     = 2'b10,  // EX/MEM ALU result
    FWD_REG_ALT = 2'b11   // unused encoding, behaves as FWD_REG
  } fwd_sel_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the execute stage.
//   a, b        : operands
//   alu_control : operation code (alu_op_e); unknown codes give 0
//   result      : operation result, ADD/SUB wrap modulo 2^XLEN
//   zero        : result == 0, used for branch resolution
module alu
  import execute_pkg::*;
#(
  parameter int unsigned XLEN = execute_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register.
//   clock, reset_n        : clock, synchronous active-low reset
//   stall, flush          : hold / bubble the EX/MEM register (flush wins)
//   *_dec                 : control and PC values from decode
//   read_data1/2, imm_extended, reg_destiny_src : operands and rd from decode
//   forward_a/b, result_to_write : forwarding selects and writeback value
//   pc_src, pc_target     : combinational fetch redirect
//   *_ex                  : registered EX/MEM outputs
module execute
#(
  parameter int unsigned XLEN = execute_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            reg_write_dec,
  input  logic [1:0]      result_src_dec,
  input  logic            mem_write_dec,
  input  logic            jump_dec,
  input  logic            branch_dec,
  input  logic [3:0]      alu_control_id_dec,
  input  logic            alu_src_dec,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm_extended,
  input  logic [XLEN-1:0] addr_current_instruction_dec,
  input  logic [XLEN-1:0] addr_next_instruction_dec,
  input  logic [4:0]      reg_destiny_src,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] result_to_write,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            reg_write_ex,
  output logic [1:0]      result_src_ex,
  output logic            mem_write_ex,
  output logic [XLEN-1:0] alu_result_ex,
  output logic [XLEN-1:0] write_data_ex,
  output logic [4:0]      reg_destiny_ex,
  output logic [XLEN-1:0] addr_next_instruction_ex
);

  import execute_pkg::*;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  always_comb begin
    fwd_a = read_data1;
    case (fwd_sel_e'(forward_a))
      FWD_WB:  fwd_a = result_to_write;
      FWD_MEM: fwd_a = alu_result_ex;
      default: fwd_a = read_data1;
    endcase
  end

  always_comb begin
    fwd_b = read_data2;
    case (fwd_sel_e'(forward_b))
      FWD_WB:  fwd_b = result_to_write;
      FWD_MEM: fwd_b = alu_result_ex;
      default: fwd_b = read_data2;
    endcase
  end

  assign src_b = alu_src_dec ? imm_extended : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a           (fwd_a),
    .b           (src_b),
    .alu_control (alu_control_id_dec),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  // Redirect is resolved here in the same cycle, independent of stall/flush.
  assign pc_target = addr_current_instruction_dec + imm_extended;
  assign pc_src    = jump_dec | (branch_dec & alu_zero);

  // Reset and flush both produce a bubble; stall holds everything.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      reg_write_ex             <= 1'b0;
      result_src_ex            <= '0;
      mem_write_ex             <= 1'b0;
      alu_result_ex            <= '0;
      write_data_ex            <= '0;
      reg_destiny_ex           <= '0;
      addr_next_instruction_ex <= '0;
    end else if (!stall) begin
      reg_write_ex             <= reg_write_dec;
      result_src_ex            <= result_src_dec;
      mem_write_ex             <= mem_write_dec;
      alu_result_ex            <= alu_result;
      write_data_ex            <= fwd_b;
      reg_destiny_ex           <= reg_destiny_src;
      addr_next_instruction_ex <= addr_next_instruction_dec;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: a behavioural reference model is compared
// against the DUT every falling edge, plus hand-computed literal checks.
module tb_execute;

  localparam int unsigned XLEN = 64;

  logic            clock;
  logic            reset_n;
  logic            stall;
  logic            flush;
  logic            reg_write_dec;
  logic [1:0]      result_src_dec;
  logic            mem_write_dec;
  logic            jump_dec;
  logic            branch_dec;
  logic [3:0]      alu_control_id_dec;
  logic            alu_src_dec;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [XLEN-1:0] imm_extended;
  logic [XLEN-1:0] addr_current_instruction_dec;
  logic [XLEN-1:0] addr_next_instruction_dec;
  logic [4:0]      reg_destiny_src;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] result_to_write;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            reg_write_ex;
  logic [1:0]      result_src_ex;
  logic            mem_write_ex;
  logic [XLEN-1:0] alu_result_ex;
  logic [XLEN-1:0] write_data_ex;
  logic [4:0]      reg_destiny_ex;
  logic [XLEN-1:0] addr_next_instruction_ex;

  int tests = 0;
  int fails = 0;

  execute #(.XLEN(XLEN)) dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .stall                        (stall),
    .flush                        (flush),
    .reg_write_dec                (reg_write_dec),
    .result_src_dec               (result_src_dec),
    .mem_write_dec                (mem_write_dec),
    .jump_dec                     (jump_dec),
    .branch_dec                   (branch_dec),
    .alu_control_id_dec           (alu_control_id_dec),
    .alu_src_dec                  (alu_src_dec),
    .read_data1                   (read_data1),
    .read_data2                   (read_data2),
    .imm_extended                 (imm_extended),
    .addr_current_instruction_dec (addr_current_instruction_dec),
    .addr_next_instruction_dec    (addr_next_instruction_dec),
    .reg_destiny_src              (reg_destiny_src),
    .forward_a                    (forward_a),
    .forward_b                    (forward_b),
    .result_to_write              (result_to_write),
    .pc_src                       (pc_src),
    .pc_target                    (pc_target),
    .reg_write_ex                 (reg_write_ex),
    .result_src_ex                (result_src_ex),
    .mem_write_ex                 (mem_write_ex),
    .alu_result_ex                (alu_result_ex),
    .write_data_ex                (write_data_ex),
    .reg_destiny_ex               (reg_destiny_ex),
    .addr_next_instruction_ex     (addr_next_instruction_ex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] alu_ref(input int op,
      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int sh;
    logic signed [XLEN-1:0] sa;
    sh = int'(b % 64);
    sa = a;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sa < $signed(b)) ? 1 : 0;
      6: return a << sh;
      7: return a >> sh;
      8: return sa >>> sh;
      9: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  logic            m_ok = 1'b0;
  logic            m_rw;
  logic [1:0]      m_rs;
  logic            m_mw;
  logic [XLEN-1:0] m_alu;
  logic [XLEN-1:0] m_wd;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_next;

  function automatic logic [XLEN-1:0] pick(input logic [1:0] sel,
      input logic [XLEN-1:0] regv);
    if (sel == 2'b01) return result_to_write;
    if (sel == 2'b10) return m_alu;
    return regv;
  endfunction

  function automatic logic [XLEN-1:0] ref_result();
    logic [XLEN-1:0] a, b;
    a = pick(forward_a, read_data1);
    b = alu_src_dec ? imm_extended : pick(forward_b, read_data2);
    return alu_ref(int'(alu_control_id_dec), a, b);
  endfunction

  always @(posedge clock) begin
    if (!reset_n || flush) begin
      m_ok <= 1'b1;
      m_rw <= 1'b0; m_rs <= 2'd0; m_mw <= 1'b0;
      m_alu <= 0; m_wd <= 0; m_rd <= 5'd0; m_next <= 0;
    end else if (!stall) begin
      m_rw   <= reg_write_dec;
      m_rs   <= result_src_dec;
      m_mw   <= mem_write_dec;
      m_alu  <= ref_result();
      m_wd   <= pick(forward_b, read_data2);
      m_rd   <= reg_destiny_src;
      m_next <= addr_next_instruction_dec;
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("m_reg_write", 64'(reg_write_ex), 64'(m_rw));
      chk("m_result_src", 64'(result_src_ex), 64'(m_rs));
      chk("m_mem_write", 64'(mem_write_ex), 64'(m_mw));
      chk("m_alu_result", alu_result_ex, m_alu);
      chk("m_write_data", write_data_ex, m_wd);
      chk("m_reg_destiny", 64'(reg_destiny_ex), 64'(m_rd));
      chk("m_addr_next", addr_next_instruction_ex, m_next);
      chk("m_pc_target", pc_target, addr_current_instruction_dec + imm_extended);
      chk("m_pc_src", 64'(pc_src),
          64'(jump_dec | (branch_dec & (ref_result() == 0))));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    stall = 0; flush = 0;
    reg_write_dec = 0; result_src_dec = 0; mem_write_dec = 0;
    jump_dec = 0; branch_dec = 0; alu_control_id_dec = 0; alu_src_dec = 0;
    read_data1 = 0; read_data2 = 0; imm_extended = 0;
    addr_current_instruction_dec = 0; addr_next_instruction_dec = 0;
    reg_destiny_src = 0; forward_a = 0; forward_b = 0; result_to_write = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg_write"}, 64'(reg_write_ex), 0);
    chk({tag, "_result_src"}, 64'(result_src_ex), 0);
    chk({tag, "_mem_write"}, 64'(mem_write_ex), 0);
    chk({tag, "_alu_result"}, alu_result_ex, 0);
    chk({tag, "_write_data"}, write_data_ex, 0);
    chk({tag, "_reg_destiny"}, 64'(reg_destiny_ex), 0);
    chk({tag, "_addr_next"}, addr_next_instruction_ex, 0);
  endtask

  task automatic load_valid(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    reg_write_dec = 1; mem_write_dec = 1; result_src_dec = 2'd1;
    alu_control_id_dec = 4'd0; alu_src_dec = 0; forward_a = 0; forward_b = 0;
    read_data1 = a; read_data2 = b; reg_destiny_src = 5'd3;
    addr_next_instruction_dec = 64'h44;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    tick();
    chk_all_zero("reset");
    reset_n = 1;

    // ADD 5 + 7
    read_data1 = 5; read_data2 = 7;
    tick();
    chk("add_result", alu_result_ex, 12);
    chk("add_wdata", write_data_ex, 7);

    // forward A from EX/MEM (12) + imm 3, store data from writeback
    forward_a = 2'b10; alu_src_dec = 1; imm_extended = 3;
    forward_b = 2'b01; result_to_write = 9; read_data2 = 100;
    tick();
    chk("fwd_result", alu_result_ex, 15);
    chk("fwd_wdata", write_data_ex, 9);

    // branch resolution, combinational
    clear_inputs();
    branch_dec = 1; alu_control_id_dec = 4'd1; read_data1 = 4; read_data2 = 4;
    addr_current_instruction_dec = 64'h100; imm_extended = 64'h20;
    #1;
    chk("beq_taken", 64'(pc_src), 1);
    chk("beq_target", pc_target, 64'h120);
    read_data2 = 5;
    #1;
    chk("beq_not_taken", 64'(pc_src), 0);
    jump_dec = 1;
    #1;
    chk("jump", 64'(pc_src), 1);
    tick();

    // stall / flush priority
    clear_inputs();
    load_valid(1, 2);
    tick();
    chk("pre_stall", alu_result_ex, 3);
    stall = 1; read_data1 = 50; reg_destiny_src = 5'd9;
    addr_next_instruction_dec = 64'h88;
    tick();
    chk("stall_alu", alu_result_ex, 3);
    chk("stall_rd", 64'(reg_destiny_ex), 3);
    chk("stall_rw", 64'(reg_write_ex), 1);
    chk("stall_next", addr_next_instruction_ex, 64'h44);
    flush = 1;
    tick();
    chk("stflush_rw", 64'(reg_write_ex), 0);
    chk("stflush_mw", 64'(mem_write_ex), 0);
    chk("stflush_alu", alu_result_ex, 0);
    stall = 0; flush = 0;
    tick();
    chk("reload_alu", alu_result_ex, 52);
    flush = 1;
    tick();
    chk_all_zero("flush");
    flush = 0;

    // arithmetic edges
    clear_inputs();
    alu_control_id_dec = 4'd5; read_data1 = '1; read_data2 = 1;
    tick();
    chk("slt_neg", alu_result_ex, 1);
    alu_control_id_dec = 4'd9;
    tick();
    chk("sltu_big", alu_result_ex, 0);
    alu_control_id_dec = 4'd0;
    tick();
    chk("add_wrap", alu_result_ex, 0);
    alu_control_id_dec = 4'd8; read_data1 = 64'h8000_0000_0000_0000;
    alu_src_dec = 1; imm_extended = 63;
    tick();
    chk("sra_63", alu_result_ex, '1);
    alu_control_id_dec = 4'd7;
    tick();
    chk("srl_63", alu_result_ex, 1);

    // sweep every opcode through the model, shift amount bits [5:0] only
    for (int op = 0; op < 16; op++) begin
      alu_control_id_dec = 4'(op);
      alu_src_dec = 0;
      read_data1 = 64'hF0F0_1234_8765_00FF;
      read_data2 = 64'h0000_0000_0000_0144;
      tick();
    end
    alu_control_id_dec = 4'd12;
    tick();
    chk("op12_zero", alu_result_ex, 0);

    // reset mid-stream with valid inputs
    load_valid(64'h77, 64'h11);
    tick();
    chk("pre_reset", alu_result_ex, 64'h88);
    reset_n = 0;
    tick();
    chk_all_zero("midreset");
    reset_n = 1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
